fpdiv_issue: RTL and testbench
==============================

// Module: fpdiv_issue
// PURPOSE
//  Issue/sequencing stage directly upstream of fpdiv. Accepts divide/sqrt requests on a valid/ready
//  port, queues them, drives fpdiv's start/operand/mode inputs with the required multi-cycle start
//  pulse, waits for done, and returns result+flags+denorm with the request tag on a valid/ready port.
//  One operation is in flight in fpdiv at a time. Operands stay stable from start until done.
// PARAMETERS
//  FIFO_DEPTH   2    request queue entries (power of 2, >=2)
//  START_CYC    2    cycles div_start is held high per operation (>=1)
//  TAG_W        4    width of opaque request tag
//  TIMEOUT_CYC  64   watchdog limit in WAIT; used only with FPDIV_ISSUE_TIMEOUT_EN
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous reset, active-low (0 = reset)
//  req_valid    in   1      request present
//  req_ready    out  1      queue not full
//  req_op1      in   64     operand 1 (single precision in [63:32], [31:0]=0)
//  req_op2      in   64     operand 2 (ignored by fpdiv for sqrt)
//  req_rm       in   3      rounding mode
//  req_op_type  in   1      0=divide, 1=sqrt
//  req_P        in   1      1=single, 0=double precision
//  req_OvEn     in   1      overflow trap enable
//  req_UnEn     in   1      underflow trap enable
//  req_tag      in   TAG_W  returned unchanged on rsp_tag
//  div_start    out  1      to fpdiv start
//  div_op1/op2  out  64     to fpdiv operands (registered)
//  div_rm, div_op_type, div_P, div_OvEn, div_UnEn  out  3/1/1/1/1  to fpdiv (registered)
//  div_done     in   1      from fpdiv done
//  div_result   in   64     from fpdiv AS_Result
//  div_flags    in   5      from fpdiv Flags
//  div_denorm   in   1      from fpdiv Denorm
//  rsp_valid    out  1      response held until accepted
//  rsp_ready    in   1      consumer accepts
//  rsp_result   out  64     captured result
//  rsp_flags    out  5      captured flags
//  rsp_denorm   out  1      captured denorm
//  rsp_tag      out  TAG_W  tag of completed request
//  rsp_timeout  out  1      only with FPDIV_ISSUE_TIMEOUT_EN
// BEHAVIOUR
//  Reset (async assert, sync release): FIFO empty, state IDLE, req_ready=1 after release, div_start=0,
//   all div_* and rsp_* outputs 0. Reset mid-operation aborts it; fpdiv shares the same reset.
//  Push when req_valid&&req_ready; req_ready = !full (no bypass on full+pop). Push+pop same cycle OK.
//  FSM: IDLE: FIFO non-empty -> pop, latch entry into div_* regs and tag, -> START.
//   START: div_start=1 for exactly START_CYC cycles (counter), then -> WAIT with div_start=0.
//   WAIT: done_q registered; capture on div_done && !done_q (rising edge) -> RESP, rsp_* loaded.
//     div_done during START, or already high on WAIT entry, is ignored until a fresh rising edge.
//   RESP: rsp_valid=1, outputs stable; rsp_valid&&rsp_ready -> IDLE, rsp_valid=0 next cycle.
//  Latency: push at cycle 0 -> div_start high from cycle 2 (pop at 1) when idle; rsp_valid the cycle
//   after the captured done edge. div_* operand regs change only on pop.
//  Back-to-back: next pop only in IDLE, i.e. one cycle after response handshake.
// CONFIGURATION
//  FPDIV_ISSUE_TIMEOUT_EN defined: cycle counter in WAIT; at TIMEOUT_CYC without done edge -> RESP
//   with rsp_result=64'h7FC0_0000_0000_0000, rsp_flags=5'b0, rsp_denorm=0, rsp_timeout=1; rsp_timeout
//   is 0 for normal completions. Not defined: no counter, no rsp_timeout port, WAIT is unbounded.
// STRUCTURE
//  fpdiv_pkg: fpdiv_req_t (op1, op2, rm, op_type, P, OvEn, UnEn, tag), issue_state_t enum
//   {IDLE, START, WAIT, RESP}, localparam QNAN_S.
//  Sub-module fpdiv_req_fifo (synchronous FIFO of fpdiv_req_t, FIFO_DEPTH, full/empty, ptr wrap).
// TESTING (bench uses fpdiv behavioural model or DUT fpdiv, single precision)
//  1 sqrt op1=64'h40800000_00000000, rm=3'b000, tag=3 -> div_start 2 cycles, rsp_result[63:32]=40000000, rsp_tag=3.
//  2 Three pushes back-to-back, rsp_ready=0 -> req_ready drops after 2 queued + 1 in flight; responses in order.
//  3 div_done held high from previous op into WAIT -> no capture until done falls and rises again.
//  4 rsp_ready low 10 cycles -> rsp_* stable, no new div_start until handshake.
//  5 Assert reset during WAIT -> all outputs 0 asynchronously, FIFO empty, next request completes normally.
//  6 TIMEOUT_EN: div_done tied 0 -> at TIMEOUT_CYC rsp_timeout=1, rsp_result=64'h7FC00000_00000000.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// Shared types for the fpdiv issue stage: queued request record, sequencer states, timeout result.
package fpdiv_pkg;

  localparam int TAG_MAX_W = 16;
  localparam logic [63:0] QNAN_S = 64'h7FC0_0000_0000_0000;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} issue_state_t;

  typedef struct packed {
    logic [63:0]          op1;
    logic [63:0]          op2;
    logic [2:0]           rm;
    logic                 op_type;
    logic                 P;
    logic                 OvEn;
    logic                 UnEn;
    logic [TAG_MAX_W-1:0] tag;
  } fpdiv_req_t;

endpackage

// File: rtl/fpdiv_req_fifo.sv
// Synchronous request queue for the fpdiv issue stage; pointers carry one wrap bit for full/empty.
module fpdiv_req_fifo
  import fpdiv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  fpdiv_req_t wr_data,
  input  logic       pop,
  output fpdiv_req_t rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  fpdiv_req_t     mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage is data only; the pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/fpdiv_issue.sv
// Issue/sequencing stage in front of fpdiv: queues requests, pulses start, waits for done, returns response.
// Optional watchdog in WAIT enabled by defining FPDIV_ISSUE_TIMEOUT_EN (adds rsp_timeout port).
module fpdiv_issue
  import fpdiv_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int START_CYC   = 2,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [63:0]      req_op1,
  input  logic [63:0]      req_op2,
  input  logic [2:0]       req_rm,
  input  logic             req_op_type,
  input  logic             req_P,
  input  logic             req_OvEn,
  input  logic             req_UnEn,
  input  logic [TAG_W-1:0] req_tag,
  output logic             div_start,
  output logic [63:0]      div_op1,
  output logic [63:0]      div_op2,
  output logic [2:0]       div_rm,
  output logic             div_op_type,
  output logic             div_P,
  output logic             div_OvEn,
  output logic             div_UnEn,
  input  logic             div_done,
  input  logic [63:0]      div_result,
  input  logic [4:0]       div_flags,
  input  logic             div_denorm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [4:0]       rsp_flags,
  output logic             rsp_denorm,
  output logic [TAG_W-1:0] rsp_tag
`ifdef FPDIV_ISSUE_TIMEOUT_EN
  ,
  output logic             rsp_timeout
`endif
);

  if (FIFO_DEPTH < 2 || START_CYC < 1 || TAG_W < 1 || TAG_W > TAG_MAX_W || TIMEOUT_CYC < 1)
  begin : g_param_check
    $error("fpdiv_issue: illegal parameter combination");
  end

  localparam int SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;

  issue_state_t   state;
  fpdiv_req_t     wr_req;
  fpdiv_req_t     head;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;
  logic           done_q;
  logic [SCW-1:0] start_cnt;
  logic [TAG_W-1:0] tag_q;

  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state == IDLE) && !empty;

  always_comb begin
    wr_req         = '0;
    wr_req.op1     = req_op1;
    wr_req.op2     = req_op2;
    wr_req.rm      = req_rm;
    wr_req.op_type = req_op_type;
    wr_req.P       = req_P;
    wr_req.OvEn    = req_OvEn;
    wr_req.UnEn    = req_UnEn;
    wr_req.tag     = TAG_MAX_W'(req_tag);
  end

  fpdiv_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_req),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

`ifdef FPDIV_ISSUE_TIMEOUT_EN
  localparam int TOW = $clog2(TIMEOUT_CYC + 1);
  logic [TOW-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      done_q      <= 1'b0;
      start_cnt   <= '0;
      tag_q       <= '0;
      div_start   <= 1'b0;
      div_op1     <= '0;
      div_op2     <= '0;
      div_rm      <= '0;
      div_op_type <= 1'b0;
      div_P       <= 1'b0;
      div_OvEn    <= 1'b0;
      div_UnEn    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_denorm  <= 1'b0;
      rsp_tag     <= '0;
`ifdef FPDIV_ISSUE_TIMEOUT_EN
      wait_cnt    <= '0;
      rsp_timeout <= 1'b0;
`endif
    end else begin
      // Edge detector on done runs every cycle so a level held across WAIT entry is not a new edge.
      done_q <= div_done;
      case (state)
        IDLE: begin
          if (!empty) begin
            div_op1     <= head.op1;
            div_op2     <= head.op2;
            div_rm      <= head.rm;
            div_op_type <= head.op_type;
            div_P       <= head.P;
            div_OvEn    <= head.OvEn;
            div_UnEn    <= head.UnEn;
            tag_q       <= TAG_W'(head.tag);
            div_start   <= 1'b1;
            start_cnt   <= '0;
            state       <= START;
          end
        end
        START: begin
          if (start_cnt == SCW'(START_CYC - 1)) begin
            div_start <= 1'b0;
            state     <= WAIT;
`ifdef FPDIV_ISSUE_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end else begin
            start_cnt <= start_cnt + SCW'(1);
          end
        end
        WAIT: begin
          if (div_done && !done_q) begin
            rsp_result  <= div_result;
            rsp_flags   <= div_flags;
            rsp_denorm  <= div_denorm;
            rsp_tag     <= tag_q;
            rsp_valid   <= 1'b1;
            state       <= RESP;
`ifdef FPDIV_ISSUE_TIMEOUT_EN
            rsp_timeout <= 1'b0;
          end else if (wait_cnt == TOW'(TIMEOUT_CYC - 1)) begin
            rsp_result  <= QNAN_S;
            rsp_flags   <= '0;
            rsp_denorm  <= 1'b0;
            rsp_tag     <= tag_q;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + TOW'(1);
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpdiv_issue.sv
// Directed bench for fpdiv_issue; the bench plays the fpdiv side with hand-computed single-precision results.
module tb_fpdiv_issue;

  localparam int TAG_W = 4;
  localparam int TO    = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [63:0]      req_op1 = '0;
  logic [63:0]      req_op2 = '0;
  logic [2:0]       req_rm = '0;
  logic             req_op_type = 1'b0;
  logic             req_P = 1'b0;
  logic             req_OvEn = 1'b0;
  logic             req_UnEn = 1'b0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             div_start;
  logic [63:0]      div_op1;
  logic [63:0]      div_op2;
  logic [2:0]       div_rm;
  logic             div_op_type;
  logic             div_P;
  logic             div_OvEn;
  logic             div_UnEn;
  logic             div_done = 1'b0;
  logic [63:0]      div_result = '0;
  logic [4:0]       div_flags = '0;
  logic             div_denorm = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [63:0]      rsp_result;
  logic [4:0]       rsp_flags;
  logic             rsp_denorm;
  logic [TAG_W-1:0] rsp_tag;
`ifdef FPDIV_ISSUE_TIMEOUT_EN
  logic             rsp_timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpdiv_issue #(
    .FIFO_DEPTH  (2),
    .START_CYC   (2),
    .TAG_W       (TAG_W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op1     (req_op1),
    .req_op2     (req_op2),
    .req_rm      (req_rm),
    .req_op_type (req_op_type),
    .req_P       (req_P),
    .req_OvEn    (req_OvEn),
    .req_UnEn    (req_UnEn),
    .req_tag     (req_tag),
    .div_start   (div_start),
    .div_op1     (div_op1),
    .div_op2     (div_op2),
    .div_rm      (div_rm),
    .div_op_type (div_op_type),
    .div_P       (div_P),
    .div_OvEn    (div_OvEn),
    .div_UnEn    (div_UnEn),
    .div_done    (div_done),
    .div_result  (div_result),
    .div_flags   (div_flags),
    .div_denorm  (div_denorm),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .rsp_denorm  (rsp_denorm),
    .rsp_tag     (rsp_tag)
`ifdef FPDIV_ISSUE_TIMEOUT_EN
    ,
    .rsp_timeout (rsp_timeout)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] op1, input logic [63:0] op2, input logic [2:0] rm,
                      input logic op_type, input logic [TAG_W-1:0] tag);
    int n;
    req_valid = 1'b1; req_op1 = op1; req_op2 = op2; req_rm = rm;
    req_op_type = op_type; req_P = 1'b1; req_OvEn = 1'b0; req_UnEn = 1'b0; req_tag = tag;
    n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    if (n >= 50) chk("push_ready_bound", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  // Runs until the issue stage has finished its start pulse and sits in WAIT.
  task automatic to_wait();
    int n;
    n = 0;
    while (!div_start && n < 60) begin tick(); n++; end
    while (div_start && n < 60) begin tick(); n++; end
    chk("reach_wait_bound", {63'd0, (n < 60)}, 64'd1);
  endtask

  task automatic fire_done(input logic [63:0] res, input logic [4:0] fl, input logic dn);
    div_result = res; div_flags = fl; div_denorm = dn; div_done = 1'b1;
    tick();
    div_done = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic stable;
    logic any_start;

    // Reset state
    #12;
    chk("rst_div_start", {63'd0, div_start}, 64'd0);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_div_op1", div_op1, 64'd0);
    #11 reset = 1'b1;
    tick();
    chk("rel_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rel_rsp_result", rsp_result, 64'd0);

    // 1: sqrt(4.0) = 2.0, tag 3, start pulse exactly two cycles
    push(64'h40800000_00000000, 64'h0, 3'b000, 1'b1, 4'd3);
    chk("t1_start_pre_pop", {63'd0, div_start}, 64'd0);
    tick();
    chk("t1_start_c1", {63'd0, div_start}, 64'd1);
    chk("t1_div_op1", div_op1, 64'h40800000_00000000);
    chk("t1_div_op_type", {63'd0, div_op_type}, 64'd1);
    chk("t1_div_P", {63'd0, div_P}, 64'd1);
    tick();
    chk("t1_start_c2", {63'd0, div_start}, 64'd1);
    tick();
    chk("t1_start_c3", {63'd0, div_start}, 64'd0);
    fire_done(64'h40000000_00000000, 5'b00000, 1'b0);
    chk("t1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t1_rsp_result", rsp_result, 64'h40000000_00000000);
    chk("t1_rsp_tag", {60'd0, rsp_tag}, 64'd3);
`ifdef FPDIV_ISSUE_TIMEOUT_EN
    chk("t1_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
`endif
    handshake();
    chk("t1_rsp_drop", {63'd0, rsp_valid}, 64'd0);

    // 3: done held high from START into WAIT is ignored until a fresh rising edge
    push(64'h3F800000_00000000, 64'h40000000_00000000, 3'b011, 1'b0, 4'd5);
    tick();
    chk("t3_div_rm", {61'd0, div_rm}, 64'd3);
    chk("t3_div_op2", div_op2, 64'h40000000_00000000);
    div_result = 64'hDEADBEEF_00000000;
    div_done = 1'b1;
    tick();
    tick();
    chk("t3_in_wait", {63'd0, div_start}, 64'd0);
    tick();
    tick();
    chk("t3_held_ignored", {63'd0, rsp_valid}, 64'd0);
    div_done = 1'b0;
    tick();
    chk("t3_fall_ignored", {63'd0, rsp_valid}, 64'd0);
    fire_done(64'h3F000000_00000000, 5'b00001, 1'b0);
    chk("t3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t3_rsp_result", rsp_result, 64'h3F000000_00000000);
    chk("t3_rsp_flags", {59'd0, rsp_flags}, 64'd1);
    chk("t3_rsp_tag", {60'd0, rsp_tag}, 64'd5);
    handshake();

    // 2 + 4: three back-to-back pushes, response stalled
    push(64'h41100000_00000000, 64'h0, 3'b000, 1'b1, 4'd1);
    push(64'h41800000_00000000, 64'h0, 3'b000, 1'b1, 4'd2);
    push(64'h42C80000_00000000, 64'h0, 3'b000, 1'b1, 4'd3);
    chk("t2_ready_full", {63'd0, req_ready}, 64'd0);
    to_wait();
    fire_done(64'h40400000_00000000, 5'b00000, 1'b0);
    chk("t2_a_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t2_a_tag", {60'd0, rsp_tag}, 64'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!(rsp_valid && !div_start && rsp_tag == 4'd1 && rsp_result == 64'h40400000_00000000))
        stable = 1'b0;
    end
    chk("t4_stall_stable", {63'd0, stable}, 64'd1);
    chk("t4_still_full", {63'd0, req_ready}, 64'd0);
    handshake();
    chk("t4_after_hs_valid", {63'd0, rsp_valid}, 64'd0);
    chk("t4_after_hs_start", {63'd0, div_start}, 64'd0);
    tick();
    chk("t2_b_start", {63'd0, div_start}, 64'd1);
    chk("t2_b_op1", div_op1, 64'h41800000_00000000);
    chk("t2_ready_back", {63'd0, req_ready}, 64'd1);
    to_wait();
    fire_done(64'h40800000_00000000, 5'b00000, 1'b0);
    chk("t2_b_tag", {60'd0, rsp_tag}, 64'd2);
    chk("t2_b_result", rsp_result, 64'h40800000_00000000);
    handshake();
    to_wait();
    fire_done(64'h41200000_00000000, 5'b00000, 1'b0);
    chk("t2_c_tag", {60'd0, rsp_tag}, 64'd3);
    chk("t2_c_result", rsp_result, 64'h41200000_00000000);
    handshake();

    // 5: reset during WAIT with one request still queued
    push(64'h40800000_00000000, 64'h0, 3'b001, 1'b1, 4'd6);
    push(64'h41100000_00000000, 64'h0, 3'b001, 1'b1, 4'd7);
    to_wait();
    #3 reset = 1'b0;
    #1;
    chk("t5_rst_start", {63'd0, div_start}, 64'd0);
    chk("t5_rst_op1", div_op1, 64'd0);
    chk("t5_rst_rm", {61'd0, div_rm}, 64'd0);
    chk("t5_rst_rsp_result", rsp_result, 64'd0);
    chk("t5_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    #3 reset = 1'b1;
    tick();
    any_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (div_start) any_start = 1'b1;
    end
    chk("t5_fifo_flushed", {63'd0, any_start}, 64'd0);
    chk("t5_ready", {63'd0, req_ready}, 64'd1);
    push(64'h41800000_00000000, 64'h0, 3'b000, 1'b1, 4'd8);
    to_wait();
    fire_done(64'h40800000_00000000, 5'b00000, 1'b1);
    chk("t5_rsp_tag", {60'd0, rsp_tag}, 64'd8);
    chk("t5_rsp_result", rsp_result, 64'h40800000_00000000);
    chk("t5_rsp_denorm", {63'd0, rsp_denorm}, 64'd1);
    handshake();

`ifdef FPDIV_ISSUE_TIMEOUT_EN
    // 6: no done edge ever; watchdog answers after TO cycles in WAIT
    push(64'h40800000_00000000, 64'h0, 3'b000, 1'b1, 4'd9);
    to_wait();
    for (int i = 0; i < TO - 1; i++) tick();
    chk("t6_not_yet", {63'd0, rsp_valid}, 64'd0);
    tick();
    chk("t6_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t6_timeout", {63'd0, rsp_timeout}, 64'd1);
    chk("t6_result", rsp_result, 64'h7FC00000_00000000);
    chk("t6_flags", {59'd0, rsp_flags}, 64'd0);
    chk("t6_tag", {60'd0, rsp_tag}, 64'd9);
    handshake();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
